// File: rtl/gate_table_checker.sv
// Sequential exhaustive tester for a 2-input combinational gate: walks {x,y}
// through 00..11, samples the gate output after SETTLE cycles, checks it against a truth table.
module gate_table_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] captured,
  output logic [3:0] mismatch,
  output logic [2:0] err_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(SETTLE - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_exp;
  logic [3:0] r_cnt;
  logic [1:0] r_idx;

  logic       w_accept;
  logic       w_sample;
  logic       w_last;
  logic       w_s_one;
  logic       w_s_bad;
  logic [2:0] w_err_nxt;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_sample  = (r_state == S_WAIT) && (r_cnt == LP_LAST);
  assign w_last    = w_sample && (r_idx == 2'd3);
  // Case comparisons make an unknown s_in record 0 and count as a failure.
  assign w_s_one   = (s_in === 1'b1);
  assign w_s_bad   = (s_in !== r_exp[r_idx]);
  assign w_err_nxt = err_count + {2'b00, w_s_bad};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_last)   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_exp     <= 4'd0;
      r_cnt     <= 4'd0;
      r_idx     <= 2'd0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      captured  <= 4'd0;
      mismatch  <= 4'd0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_exp     <= expected;
        r_idx     <= 2'd0;
        r_cnt     <= 4'd0;
        x         <= 1'b0;
        y         <= 1'b0;
        busy      <= 1'b1;
        pass      <= 1'b0;
        captured  <= 4'd0;
        mismatch  <= 4'd0;
        err_count <= 3'd0;
      end else if (w_sample) begin
        captured[r_idx] <= w_s_one;
        mismatch[r_idx] <= w_s_bad;
        err_count       <= w_err_nxt;
        if (w_last) begin
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (w_err_nxt == 3'd0);
        end else begin
          r_idx  <= r_idx + 2'd1;
          {x, y} <= r_idx + 2'd1;
          r_cnt  <= 4'd0;
        end
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_table_checker.sv
// Scoreboard bench for gate_table_checker: two instances (SETTLE=1 and SETTLE=3)
// each driving a gate model built from NAND/NOR primitives.
module tb_gate_table_checker;

  typedef struct {
    logic [3:0] cap;
    logic [3:0] mm;
    logic [2:0] err;
    logic       pas;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start3;
  logic [3:0] exp1, exp3;
  logic [1:0] gsel1, gsel3;
  logic       s_in1, s_in3;
  logic       x1, y1, busy1, done1, pass1;
  logic       x3, y3, busy3, done3, pass3;
  logic [3:0] cap1, mm1, cap3, mm3;
  logic [2:0] err1, err3;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  function automatic logic nor2(input logic a, input logic b);
    return ~(a | b);
  endfunction

  // 0: AND from NAND, 1: XNOR from NOR, 2: OR from NOR, 3: NAND
  function automatic logic gate(input logic [1:0] sel, input logic a, input logic b);
    logic n, m, u, v;
    n = nand2(a, b);
    m = nor2(a, b);
    u = nor2(a, m);
    v = nor2(b, m);
    case (sel)
      2'd0:    return nand2(n, n);
      2'd1:    return nor2(u, v);
      2'd2:    return nor2(m, m);
      default: return n;
    endcase
  endfunction

  assign s_in1 = gate(gsel1, x1, y1);
  assign s_in3 = gate(gsel3, x3, y3);

  gate_table_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .s_in(s_in1),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .captured(cap1), .mismatch(mm1), .err_count(err1)
  );

  gate_table_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .s_in(s_in3),
    .x(x3), .y(y3), .busy(busy3), .done(done3), .pass(pass3),
    .captured(cap3), .mismatch(mm3), .err_count(err3)
  );

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input logic [3:0] cap,
                              input logic [3:0] mm, input logic [2:0] err, input logic pas);
    chk({tag, "_done_cycle"}, cyc, e.cyc);
    chk({tag, "_captured"}, int'(cap), int'(e.cap));
    chk({tag, "_mismatch"}, int'(mm), int'(e.mm));
    chk({tag, "_err_count"}, int'(err), int'(e.err));
    chk({tag, "_pass"}, int'(pas), int'(e.pas));
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e = q1.pop_front();
          check_result("run1", e, cap1, mm1, err1, pass1);
        end
      end
      if (done3) begin
        if (q3.size() == 0) chk("unexpected_done3", 1, 0);
        else begin
          e = q3.pop_front();
          check_result("run3", e, cap3, mm3, err3, pass3);
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero1(input string tag);
    chk({tag, "_xy"}, int'({x1, y1}), 0);
    chk({tag, "_busy"}, int'(busy1), 0);
    chk({tag, "_done"}, int'(done1), 0);
    chk({tag, "_pass"}, int'(pass1), 0);
    chk({tag, "_captured"}, int'(cap1), 0);
    chk({tag, "_mismatch"}, int'(mm1), 0);
    chk({tag, "_err_count"}, int'(err1), 0);
  endtask

  // Called #1 after a posedge; returns #1 after the accept edge E0.
  task automatic run1(input logic [1:0] sel, input logic [3:0] tbl, input logic [3:0] cap,
                      input logic [3:0] mm, input logic [2:0] err, input logic pas);
    gsel1  = sel;
    exp1   = tbl;
    start1 = 1'b1;
    q1.push_back('{cap, mm, err, pas, cyc + 5});
    step(1);
    start1 = 1'b0;
  endtask

  initial begin
    int nbusy;
    int base;
    rst_n  = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    exp1   = 4'd0;
    exp3   = 4'd0;
    gsel1  = 2'd0;
    gsel3  = 2'd2;
    fork
      monitor();
    join_none

    step(2);
    check_zero1("reset");
    chk("reset_busy3", int'(busy3), 0);
    rst_n = 1'b1;
    step(1);

    // AND from NAND, correct table: walk 00,01,10,11 one per cycle
    run1(2'd0, 4'b1000, 4'b1000, 4'b0000, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("and_xy", int'({x1, y1}), i);
      chk("and_busy", int'(busy1), 1);
      step(1);
    end
    step(1);
    chk("and_idle_busy", int'(busy1), 0);
    chk("and_hold_xy", int'({x1, y1}), 3);

    // XNOR from NOR against an XOR table: every vector fails
    run1(2'd1, 4'b0110, 4'b1001, 4'b1111, 3'd4, 1'b0);
    step(5);

    // OR from NOR with SETTLE=3
    exp3   = 4'b1110;
    start3 = 1'b1;
    q3.push_back('{4'b1110, 4'b0000, 3'd0, 1'b1, cyc + 13});
    step(1);
    start3 = 1'b0;
    nbusy  = 0;
    for (int i = 0; i < 12; i++) begin
      chk("or3_xy", int'({x3, y3}), i / 3);
      if (busy3) nbusy++;
      step(1);
    end
    chk("or3_busy_cycles", nbusy, 12);
    chk("or3_busy_end", int'(busy3), 0);
    step(2);

    // start pulsed mid-run must not restart or relatch
    run1(2'd0, 4'b1000, 4'b1000, 4'b0000, 3'd0, 1'b1);
    step(1);
    exp1   = 4'b0000;
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    step(6);
    chk("midstart_busy", int'(busy1), 0);

    // reset mid-run: everything clears, no done
    gsel1  = 2'd3;
    exp1   = 4'b0111;
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    step(1);
    chk("abort_pre_captured", int'(cap1), 1);
    rst_n = 1'b0;
    step(1);
    check_zero1("abort");
    rst_n = 1'b1;
    step(6);
    run1(2'd3, 4'b0111, 4'b0111, 4'b0000, 3'd0, 1'b1);
    step(6);

    // start held high: re-accepted in each done cycle, runs every 5 cycles
    gsel1  = 2'd0;
    exp1   = 4'b1000;
    start1 = 1'b1;
    base   = cyc;
    for (int k = 0; k < 3; k++)
      q1.push_back('{4'b1000, 4'b0000, 3'd0, 1'b1, base + 5 + 5 * k});
    step(6);
    chk("b2b_clear_captured", int'(cap1), 0);
    chk("b2b_clear_pass", int'(pass1), 0);
    chk("b2b_clear_err", int'(err1), 0);
    chk("b2b_busy", int'(busy1), 1);
    step(8);
    start1 = 1'b0;
    step(4);
    chk("b2b_idle", int'(busy1), 0);

    for (int i = 0; i < 40 && (q1.size() != 0 || q3.size() != 0); i++) step(1);
    chk("pending_runs1", q1.size(), 0);
    chk("pending_runs3", q3.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
